// File: rtl/lbuf_sched_if.sv
// lbuf_sched_if: line-buffer scheduler bus bundling the sprite writer handshake,
// scan-out read port and the two external single-port bank RAMs.
// Signals (slave = scheduler side):
//   line_start        scanline boundary pulse
//   wreq/wx/wdata     writer request, pixel x, colour (0 = transparent)
//   wrdy              writer ready
//   rx/rdata          scan-out pixel x, registered scan-out colour
//   bN_ad/we/di/do    bank N address, write enable, write data, read data
interface lbuf_sched_if;
    logic       line_start;
    logic       wreq;
    logic [8:0] wx;
    logic [7:0] wdata;
    logic       wrdy;
    logic [8:0] rx;
    logic [7:0] rdata;
    logic [8:0] b0_ad;
    logic       b0_we;
    logic [7:0] b0_di;
    logic [7:0] b0_do;
    logic [8:0] b1_ad;
    logic       b1_we;
    logic [7:0] b1_di;
    logic [7:0] b1_do;
    modport master (
        output line_start, wreq, wx, wdata, rx, b0_do, b1_do,
        input  wrdy, rdata, b0_ad, b0_we, b0_di, b1_ad, b1_we, b1_di
    );
    modport slave (
        input  line_start, wreq, wx, wdata, rx, b0_do, b1_do,
        output wrdy, rdata, b0_ad, b0_we, b0_di, b1_ad, b1_we, b1_di
    );
endinterface

// File: rtl/lbuf_sched.sv
// lbuf_sched: double-buffered sprite line buffer scheduler with erase-after-read scan-out.
// Ports: clk (rising edge), rst_n (async active-low), bus (lbuf_sched_if.slave).
// Optional macro LBUF_PRIO_EN: first-written-wins via read-check-write (1 pixel per 2 CLK);
// undefined: last-written-wins, 1 pixel per CLK.
module lbuf_sched (
    input  logic        clk,
    input  logic        rst_n,
    lbuf_sched_if.slave bus
);
    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;
    logic [0:0] r_state;
    logic [8:0] r_cnt;
    logic       r_bsel;
    logic       r_ph;
    logic [8:0] r_rxq;
    logic [7:0] r_rdata;
    logic       w_run;
    logic       w_wacc;
    logic       w_wr_we;
    logic [8:0] w_wr_ad;
    logic [7:0] w_wr_di;
    logic       w_rd_we;
    assign w_run   = r_state == S_RUN;
    // the read bank erases the pixel it just returned on the second half of each pixel clock
    assign w_rd_we = w_run & r_ph;
`ifdef LBUF_PRIO_EN
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_CHK  = 1'b1;
    logic [0:0] r_wst;
    logic [8:0] r_wx;
    logic [7:0] r_wdata;
    logic [7:0] w_wr_do;
    assign w_wr_do  = r_bsel ? bus.b1_do : bus.b0_do;
    assign bus.wrdy = w_run & (r_wst == W_IDLE) & ~bus.line_start;
    assign w_wacc   = bus.wreq & bus.wrdy;
    // acceptance cycle reads the target pixel; check cycle writes only over transparent
    assign w_wr_ad  = (r_wst == W_CHK) ? r_wx : bus.wx;
    assign w_wr_di  = r_wdata;
    assign w_wr_we  = (r_wst == W_CHK) & ~bus.line_start & (w_wr_do == 8'd0) & (r_wdata != 8'd0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wst   <= W_IDLE;
            r_wx    <= 9'd0;
            r_wdata <= 8'd0;
        end else if (bus.line_start || r_wst == W_CHK) begin
            r_wst <= W_IDLE;
        end else if (w_wacc) begin
            r_wst   <= W_CHK;
            r_wx    <= bus.wx;
            r_wdata <= bus.wdata;
        end
    end
`else
    assign bus.wrdy = w_run & ~bus.line_start;
    assign w_wacc   = bus.wreq & bus.wrdy;
    assign w_wr_ad  = bus.wx;
    assign w_wr_di  = bus.wdata;
    assign w_wr_we  = w_wacc & (bus.wdata != 8'd0);
`endif
    // write bank = r_bsel, read bank = ~r_bsel; INIT clears both banks in parallel
    assign bus.b0_ad = w_run ? (r_bsel ? r_rxq : w_wr_ad) : r_cnt;
    assign bus.b1_ad = w_run ? (r_bsel ? w_wr_ad : r_rxq) : r_cnt;
    // gated by rst_n so no RAM write can occur while reset is held
    assign bus.b0_we = rst_n & (~w_run | (r_bsel ? w_rd_we : w_wr_we));
    assign bus.b1_we = rst_n & (~w_run | (r_bsel ? w_wr_we : w_rd_we));
    assign bus.b0_di = (w_run & ~r_bsel) ? w_wr_di : 8'd0;
    assign bus.b1_di = (w_run & r_bsel) ? w_wr_di : 8'd0;
    assign bus.rdata = r_rdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
            r_cnt   <= 9'd0;
            r_bsel  <= 1'b0;
            r_ph    <= 1'b0;
            r_rxq   <= 9'd0;
            r_rdata <= 8'd0;
        end else if (!w_run) begin
            r_cnt <= r_cnt + 9'd1;
            if (r_cnt == 9'd511)
                r_state <= S_RUN;
        end else begin
            r_ph <= bus.line_start ? 1'b0 : ~r_ph;
            if (bus.line_start)
                r_bsel <= ~r_bsel;
            if (!r_ph) begin
                r_rxq   <= bus.rx;
                r_rdata <= r_bsel ? bus.b0_do : bus.b1_do;
            end
        end
    end
endmodule

// File: tb/tb_lbuf_sched.sv
// tb_lbuf_sched: directed self-checking bench for lbuf_sched with behavioural bank RAMs.
module tb_lbuf_sched;
`ifdef LBUF_PRIO_EN
    localparam logic [7:0] EXP_B2B  = 8'h03;
    localparam logic       EXP_RDY2 = 1'b0;
`else
    localparam logic [7:0] EXP_B2B  = 8'h09;
    localparam logic       EXP_RDY2 = 1'b1;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [7:0] mem0 [512];
    logic [7:0] mem1 [512];
    lbuf_sched_if bus ();
    lbuf_sched dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );
    always #5 clk = ~clk;
    // synchronous read-before-write RAMs; reset scribbles them so INIT clearing is observable
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 512; i++) begin
                mem0[i] <= 8'hAA;
                mem1[i] <= 8'hAA;
            end
        end else begin
            bus.b0_do <= mem0[bus.b0_ad];
            bus.b1_do <= mem1[bus.b1_ad];
            if (bus.b0_we) mem0[bus.b0_ad] <= bus.b0_di;
            if (bus.b1_we) mem1[bus.b1_ad] <= bus.b1_di;
        end
    end
    task automatic wait_init(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (bus.wrdy) break;
            n++;
            @(posedge clk);
            @(negedge clk);
        end
    endtask
    task automatic write_px(input logic [8:0] x, input logic [7:0] d);
        bus.wreq = 1'b1;
        bus.wx = x;
        bus.wdata = d;
        for (int i = 0; i < 10 && !bus.wrdy; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        bus.wreq = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic swap();
        bus.line_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.line_start = 1'b0;
    endtask
    task automatic read_at(input logic [8:0] x, output logic [7:0] d);
        swap();
        bus.rx = x;
        repeat (3) @(posedge clk);
        @(negedge clk);
        d = bus.rdata;
    endtask
    task automatic test_reset();
        int n;
        int nz;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rdata !== 8'd0) begin errors++; $display("FAIL rst_rdata: got %0h expected 0", bus.rdata); end
        checks++; if (bus.wrdy !== 1'b0) begin errors++; $display("FAIL rst_wrdy: got %0b expected 0", bus.wrdy); end
        checks++; if (bus.b0_we !== 1'b0) begin errors++; $display("FAIL rst_b0_we: got %0b expected 0", bus.b0_we); end
        checks++; if (bus.b1_we !== 1'b0) begin errors++; $display("FAIL rst_b1_we: got %0b expected 0", bus.b1_we); end
        rst_n = 1'b1;
        #1;
        checks++; if ({bus.b0_we, bus.b1_we} !== 2'b11) begin errors++; $display("FAIL init_we: got %b expected 11", {bus.b0_we, bus.b1_we}); end
        checks++; if (bus.b0_ad !== 9'd0 || bus.b1_ad !== 9'd0) begin errors++; $display("FAIL init_ad: got %0d/%0d expected 0/0", bus.b0_ad, bus.b1_ad); end
        checks++; if (bus.b0_di !== 8'd0 || bus.b1_di !== 8'd0) begin errors++; $display("FAIL init_di: got %0h/%0h expected 0/0", bus.b0_di, bus.b1_di); end
        wait_init(n);
        checks++; if (n !== 512) begin errors++; $display("FAIL init_len: got %0d cycles expected 512", n); end
        checks++; if (bus.wrdy !== 1'b1) begin errors++; $display("FAIL run_wrdy: got %0b expected 1", bus.wrdy); end
        nz = 0;
        for (int i = 0; i < 512; i++) if (mem0[i] !== 8'd0 || mem1[i] !== 8'd0) nz++;
        checks++; if (nz !== 0) begin errors++; $display("FAIL init_clear: got %0d nonzero pixels expected 0", nz); end
    endtask
    task automatic test_write_read();
        logic [7:0] d;
        bus.wreq = 1'b1; bus.wx = 9'd10; bus.wdata = 8'h05;
        #1;
        checks++; if (bus.wrdy !== 1'b1) begin errors++; $display("FAIL wr_wrdy: got %0b expected 1", bus.wrdy); end
        write_px(9'd10, 8'h05);
        read_at(9'd10, d);
        checks++; if (d !== 8'h05) begin errors++; $display("FAIL rd_x10: got %0h expected 05", d); end
        checks++; if (mem0[10] !== 8'h00) begin errors++; $display("FAIL erase_x10: got %0h expected 00", mem0[10]); end
        swap();
        read_at(9'd10, d);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reread_x10: got %0h expected 00", d); end
    endtask
    task automatic test_transparent();
        logic [7:0] d;
        write_px(9'd20, 8'h07);
        checks++; if (mem1[20] !== 8'h07) begin errors++; $display("FAIL wr_x20: got %0h expected 07", mem1[20]); end
        bus.wreq = 1'b1; bus.wx = 9'd20; bus.wdata = 8'h00;
        #1;
        checks++; if (bus.wrdy !== 1'b1) begin errors++; $display("FAIL tr_wrdy: got %0b expected 1", bus.wrdy); end
        checks++; if (bus.b1_we !== 1'b0) begin errors++; $display("FAIL tr_we: got %0b expected 0", bus.b1_we); end
        @(posedge clk);
        @(negedge clk);
        bus.wreq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        read_at(9'd20, d);
        checks++; if (d !== 8'h07) begin errors++; $display("FAIL tr_rd: got %0h expected 07", d); end
    endtask
    task automatic test_back_to_back();
        logic [7:0] d;
        bus.wreq = 1'b1; bus.wx = 9'd30; bus.wdata = 8'h03;
        #1;
        checks++; if (bus.wrdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy1: got %0b expected 1", bus.wrdy); end
        @(posedge clk);
        @(negedge clk);
        bus.wdata = 8'h09;
        #1;
        checks++; if (bus.wrdy !== EXP_RDY2) begin errors++; $display("FAIL b2b_rdy2: got %0b expected %0b", bus.wrdy, EXP_RDY2); end
`ifdef LBUF_PRIO_EN
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.wrdy !== 1'b1) begin errors++; $display("FAIL b2b_rdy3: got %0b expected 1", bus.wrdy); end
`endif
        @(posedge clk);
        @(negedge clk);
        bus.wreq = 1'b0;
        @(posedge clk);
        @(negedge clk);
        read_at(9'd30, d);
        checks++; if (d !== EXP_B2B) begin errors++; $display("FAIL b2b_rd: got %0h expected %0h", d, EXP_B2B); end
    endtask
    task automatic test_line_start_coincident();
        write_px(9'd50, 8'h66);
        bus.line_start = 1'b1; bus.wreq = 1'b1; bus.wx = 9'd40; bus.wdata = 8'h0C;
        #1;
        checks++; if (bus.wrdy !== 1'b0) begin errors++; $display("FAIL ls_wrdy: got %0b expected 0", bus.wrdy); end
        checks++; if (bus.b1_we !== 1'b0) begin errors++; $display("FAIL ls_we: got %0b expected 0", bus.b1_we); end
        @(posedge clk);
        @(negedge clk);
        bus.line_start = 1'b0; bus.wreq = 1'b0; bus.rx = 9'd50;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL ls_early: got %0h expected 00", bus.rdata); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.rdata !== 8'h66) begin errors++; $display("FAIL ls_rd: got %0h expected 66", bus.rdata); end
        checks++; if (mem1[40] !== 8'h00) begin errors++; $display("FAIL ls_nowrite: got %0h expected 00", mem1[40]); end
    endtask
    task automatic test_wrap();
        logic [7:0] d;
        write_px(9'd511, 8'hA5);
        read_at(9'd511, d);
        checks++; if (d !== 8'hA5) begin errors++; $display("FAIL wrap_rd: got %0h expected a5", d); end
    endtask
    task automatic test_reset_mid();
        logic [7:0] d;
        int n;
        int nz;
        write_px(9'd60, 8'h3C);
        read_at(9'd60, d);
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL mid_rd: got %0h expected 3c", d); end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.rdata !== 8'h00) begin errors++; $display("FAIL mid_rdata: got %0h expected 00", bus.rdata); end
        checks++; if (bus.wrdy !== 1'b0) begin errors++; $display("FAIL mid_wrdy: got %0b expected 0", bus.wrdy); end
        checks++; if ({bus.b0_we, bus.b1_we} !== 2'b00) begin errors++; $display("FAIL mid_we: got %b expected 00", {bus.b0_we, bus.b1_we}); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rx = 9'd0;
        wait_init(n);
        checks++; if (n !== 512) begin errors++; $display("FAIL mid_init_len: got %0d cycles expected 512", n); end
        nz = 0;
        for (int i = 0; i < 512; i++) if (mem0[i] !== 8'd0 || mem1[i] !== 8'd0) nz++;
        checks++; if (nz !== 0) begin errors++; $display("FAIL mid_clear: got %0d nonzero pixels expected 0", nz); end
        write_px(9'd70, 8'h11);
        checks++; if (mem0[70] !== 8'h11 || mem1[70] !== 8'h00) begin errors++; $display("FAIL mid_bsel: got %0h/%0h expected 11/00", mem0[70], mem1[70]); end
    endtask
    initial begin
        bus.line_start = 1'b0;
        bus.wreq = 1'b0;
        bus.wx = 9'd0;
        bus.wdata = 8'd0;
        bus.rx = 9'd0;
        test_reset();
        test_write_read();
        test_transparent();
        test_back_to_back();
        test_line_start_coincident();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/lbuf_sched.md
LBUF_SCHED -- requirements
Module: lbuf_sched

Interface
REQ-001 CLK  in  1  single system clock; all state updates on rising edge.
REQ-002 RSTn  in  1  asynchronous active-low reset.
REQ-003 LINE_START  in  1  one-cycle pulse at scanline boundary; swaps banks.
REQ-004 WREQ  in  1  sprite-writer pixel request.
REQ-005 WX  in  9  writer pixel x.
REQ-006 WDATA  in  8  writer colour index; 0 = transparent.
REQ-007 WRDY  out  1  writer ready; a write is accepted on an edge where WREQ & WRDY.
REQ-008 RX  in  9  scan-out pixel x, held for 2 CLK (pixel clock = CLK/2).
REQ-009 RDATA  out  8  registered scan-out colour.
REQ-010 B0_AD, B1_AD  out  9  bank 0/1 address.
REQ-011 B0_WE, B1_WE  out  1  bank 0/1 write enable.
REQ-012 B0_DI, B1_DI  out  8  bank 0/1 write data.
REQ-013 B0_DO, B1_DO  in  8  bank 0/1 read data; synchronous, read-before-write, 1-cycle latency.

Function
REQ-014 Bank select BSEL: write bank = BSEL, read bank = ~BSEL.
REQ-015 States INIT and RUN; INIT -> RUN after counter CNT passes 511; no other transitions except reset.
REQ-016 INIT: both banks AD=CNT, WE=1, DI=0 each cycle, CNT+1 per cycle; 512 cycles; WRDY=0, RDATA=0, LINE_START ignored.
REQ-017 RUN: phase bit PH toggles every CLK; read bank AD = RXQ in both phases.
REQ-018 Edge with PH=0: RXQ <= RX, RDATA <= read-bank DO.
REQ-019 Edge with PH=1: read bank WE=1, DI=0 at RXQ (erase-after-read; old data returned on DO).
REQ-020 RDATA latency: RX sampled at edge e (PH=0) appears on RDATA after edge e+2.
REQ-021 Write path (macro off): WRDY = RUN & ~LINE_START; accepted pixel with WDATA!=0 drives write bank AD=WX, DI=WDATA, WE=1 in the acceptance cycle; WDATA=0 accepted, no WE.
REQ-022 LINE_START in RUN: BSEL toggles, PH <= 0, pending write FSM returns to idle; same-cycle WREQ not accepted (WRDY=0).
REQ-023 Read and write banks never both receive a write to the same bank in one cycle; bank WE/AD/DI of the write bank are idle (WE=0) when no write.
REQ-024 WX/RX wrap: 9-bit address, values 0..511 all valid; no saturation.

Reset
REQ-025 RSTn low: state=INIT, CNT=0, BSEL=0, PH=0, RXQ=0, RDATA=0, WRDY=0, write FSM idle; all WE=0 while RSTn low.
REQ-026 Reset mid-RUN or mid-INIT restarts full 512-cycle INIT after RSTn deasserts.

Configuration
REQ-027 Macro LBUF_PRIO_EN defined: first-written-wins; write FSM WIDLE/WCHK; WRDY = RUN & WIDLE & ~LINE_START.
REQ-028 With LBUF_PRIO_EN: acceptance drives write bank AD=WX, WE=0, latches WX/WDATA, -> WCHK; in WCHK write latched WDATA iff bank DO==0 and WDATA!=0, -> WIDLE; max 1 pixel per 2 CLK.
REQ-029 Without LBUF_PRIO_EN: last-written-wins per REQ-021, 1 pixel per CLK, no WCHK state.

Verification
REQ-030 Reset release -> WRDY=0 for exactly 512 cycles, both banks all-zero, then WRDY=1.
REQ-031 Write x=10 data 0x05, LINE_START, RX=10 -> RDATA=0x05 two edges after RX sampled; re-read x=10 after next swap -> 0x00.
REQ-032 WREQ with WDATA=0 at x=20 over existing 0x07 -> bank unchanged, 0x07 read back.
REQ-033 Two writes x=30 (0x03 then 0x09): macro off -> 0x09; LBUF_PRIO_EN -> 0x03, WRDY low every second cycle.
REQ-034 WREQ coincident with LINE_START -> not accepted, WRDY=0 that cycle, BSEL toggled, PH=0.
REQ-035 RSTn pulsed low mid-line -> RDATA=0 immediately, BSEL=0, full INIT repeated.
